// File: rtl/instr_fetch_decode_if.sv
// Program-memory read bus, decoded-instruction issue channel and execute redirect
// for the CPU front end. master = fetch/decode side, slave = memory/control/execute side.
interface instr_fetch_decode_if #(
  parameter int ADDR_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  logic [2:0]        opcode;
  logic              imm_flag;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  logic              issue_valid;
  logic              issue_ready;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;

  modport master (
    output mem_req, mem_addr, opcode, imm_flag, rd, rs, imm, issue_valid,
    input  mem_rdata, mem_ack, issue_ready, redirect_valid, redirect_addr
  );

  modport slave (
    input  mem_req, mem_addr, opcode, imm_flag, rd, rs, imm, issue_valid,
    output mem_rdata, mem_ack, issue_ready, redirect_valid, redirect_addr
  );
endinterface

// File: rtl/instr_fetch_decode.sv
// Front-end sequencer of the 8-bit CPU: fetches 1/2-byte instructions, splits them
// into fields and holds each one under a valid/ready issue handshake to control_unit.
module instr_fetch_decode #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] PC_RESET = '0,
  parameter int                CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  instr_fetch_decode_if.master bus,
  output logic                 halted,
  output logic [ADDR_W-1:0]    pc,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [7:0] HALT_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH0 = 3'd1,
    FETCH1 = 3'd2,
    ISSUE  = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] ir;
  logic [7:0] imm_q;
  logic       mem_req_q;
  logic       issue_valid_q;

  // Request/valid flags are registered alongside each transition so no input reaches an output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pc            <= PC_RESET;
      ir            <= '0;
      imm_q         <= '0;
      instr_count   <= '0;
      mem_req_q     <= 1'b0;
      issue_valid_q <= 1'b0;
      halted        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH0;
            mem_req_q <= 1'b1;
          end
        end

        FETCH0: begin
          // A redirect outranks a coincident ack; the fetch restarts at the new address.
          if (bus.redirect_valid) begin
            pc <= bus.redirect_addr;
          end else if (bus.mem_ack) begin
            ir <= bus.mem_rdata;
            pc <= pc + ADDR_W'(1);
            if (bus.mem_rdata == HALT_BYTE) begin
              state     <= HALT;
              mem_req_q <= 1'b0;
              halted    <= 1'b1;
            end else if (bus.mem_rdata[4]) begin
              state <= FETCH1;
            end else begin
              imm_q         <= '0;
              state         <= ISSUE;
              mem_req_q     <= 1'b0;
              issue_valid_q <= 1'b1;
            end
          end
        end

        FETCH1: begin
          if (bus.redirect_valid) begin
            pc    <= bus.redirect_addr;
            state <= FETCH0;
          end else if (bus.mem_ack) begin
            imm_q         <= bus.mem_rdata;
            pc            <= pc + ADDR_W'(1);
            state         <= ISSUE;
            mem_req_q     <= 1'b0;
            issue_valid_q <= 1'b1;
          end
        end

        ISSUE: begin
          if (bus.issue_ready) begin
            instr_count <= instr_count + CNT_W'(1);
          end
          if (bus.redirect_valid || bus.issue_ready) begin
            if (bus.redirect_valid) begin
              pc <= bus.redirect_addr;
            end
            state         <= FETCH0;
            mem_req_q     <= 1'b1;
            issue_valid_q <= 1'b0;
          end
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state         <= IDLE;
          mem_req_q     <= 1'b0;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = pc;
  assign bus.issue_valid = issue_valid_q;
  assign bus.opcode      = ir[7:5];
  assign bus.imm_flag    = ir[4];
  assign bus.rd          = ir[3:2];
  assign bus.rs          = ir[1:0];
  assign bus.imm         = imm_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: two instances (PC_RESET 0 and FF) against a byte-list
// model of the fetch/issue rules, plus hand-computed literal expectations.
module tb_instr_fetch_decode;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic       start_r    [2];
  logic       ready_r    [2];
  logic       redir_v    [2];
  logic [7:0] redir_a    [2];
  logic       ack_r      [2];
  logic [7:0] rdata_r    [2];
  int         delay      [2];
  logic [7:0] mem        [2][256];

  logic       o_req      [2];
  logic [7:0] o_addr     [2];
  logic [2:0] o_op       [2];
  logic       o_if       [2];
  logic [1:0] o_rd       [2];
  logic [1:0] o_rs       [2];
  logic [7:0] o_imm      [2];
  logic       o_iv       [2];
  logic       o_halt     [2];
  logic [7:0] o_pc       [2];
  logic [15:0] o_cnt     [2];

  logic        halted0, halted1;
  logic [7:0]  pc0, pc1;
  logic [15:0] cnt0, cnt1;

  instr_fetch_decode_if #(.ADDR_W(8)) bus0 ();
  instr_fetch_decode_if #(.ADDR_W(8)) bus1 ();

  instr_fetch_decode #(.ADDR_W(8), .PC_RESET(8'h00), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .bus(bus0.master),
    .halted(halted0), .pc(pc0), .instr_count(cnt0)
  );

  instr_fetch_decode #(.ADDR_W(8), .PC_RESET(8'hFF), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .bus(bus1.master),
    .halted(halted1), .pc(pc1), .instr_count(cnt1)
  );

  assign bus0.mem_ack        = ack_r[0];
  assign bus0.mem_rdata      = rdata_r[0];
  assign bus0.issue_ready    = ready_r[0];
  assign bus0.redirect_valid = redir_v[0];
  assign bus0.redirect_addr  = redir_a[0];
  assign bus1.mem_ack        = ack_r[1];
  assign bus1.mem_rdata      = rdata_r[1];
  assign bus1.issue_ready    = ready_r[1];
  assign bus1.redirect_valid = redir_v[1];
  assign bus1.redirect_addr  = redir_a[1];

  assign o_req[0] = bus0.mem_req;     assign o_req[1] = bus1.mem_req;
  assign o_addr[0] = bus0.mem_addr;   assign o_addr[1] = bus1.mem_addr;
  assign o_op[0] = bus0.opcode;       assign o_op[1] = bus1.opcode;
  assign o_if[0] = bus0.imm_flag;     assign o_if[1] = bus1.imm_flag;
  assign o_rd[0] = bus0.rd;           assign o_rd[1] = bus1.rd;
  assign o_rs[0] = bus0.rs;           assign o_rs[1] = bus1.rs;
  assign o_imm[0] = bus0.imm;         assign o_imm[1] = bus1.imm;
  assign o_iv[0] = bus0.issue_valid;  assign o_iv[1] = bus1.issue_valid;
  assign o_halt[0] = halted0;         assign o_halt[1] = halted1;
  assign o_pc[0] = pc0;               assign o_pc[1] = pc1;
  assign o_cnt[0] = cnt0;             assign o_cnt[1] = cnt1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: an instruction is the list of bytes fetched so far; it is issuable once the
  // list holds as many bytes as its first byte announces.
  logic        m_run  [2];
  logic        m_halt [2];
  logic [7:0]  m_pc   [2];
  logic [15:0] m_cnt  [2];
  int          m_n    [2];
  logic [7:0]  m_byte [2][2];

  function automatic bit m_complete(input int i);
    int need;
    if (m_n[i] == 0) return 1'b0;
    need = m_byte[i][0][4] ? 2 : 1;
    return m_n[i] == need;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i]  <= 1'b0;
        m_halt[i] <= 1'b0;
        m_cnt[i]  <= '0;
        m_n[i]    <= 0;
      end
      m_pc[0] <= 8'h00;
      m_pc[1] <= 8'hFF;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_run[i]) begin
          if (start_r[i]) m_run[i] <= 1'b1;
        end else if (!m_halt[i]) begin
          if (m_complete(i)) begin
            if (ready_r[i]) m_cnt[i] <= m_cnt[i] + 16'd1;
            if (redir_v[i] || ready_r[i]) m_n[i] <= 0;
            if (redir_v[i]) m_pc[i] <= redir_a[i];
          end else if (redir_v[i]) begin
            m_pc[i] <= redir_a[i];
            m_n[i]  <= 0;
          end else if (ack_r[i]) begin
            if (m_n[i] == 0 && rdata_r[i] == 8'hFF) begin
              m_halt[i] <= 1'b1;
            end else begin
              m_byte[i][m_n[i]] <= rdata_r[i];
              m_n[i] <= m_n[i] + 1;
            end
            m_pc[i] <= m_pc[i] + 8'd1;
          end
        end
      end
    end
  end

  task automatic check_output(input string name, input int i,
                              input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s dut%0d at %0t: got %0h expected %0h", name, i, $time, got, exp);
    end
  endtask

  // Compare every DUT output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check_output("mem_req", i, 32'(o_req[i]), 32'(m_run[i] && !m_halt[i] && !m_complete(i)));
        check_output("issue_valid", i, 32'(o_iv[i]), 32'(m_complete(i)));
        check_output("mem_addr", i, 32'(o_addr[i]), 32'(m_pc[i]));
        check_output("pc", i, 32'(o_pc[i]), 32'(m_pc[i]));
        check_output("halted", i, 32'(o_halt[i]), 32'(m_halt[i]));
        check_output("instr_count", i, 32'(o_cnt[i]), 32'(m_cnt[i]));
        if (m_complete(i)) begin
          check_output("opcode", i, 32'(o_op[i]), 32'(m_byte[i][0][7:5]));
          check_output("imm_flag", i, 32'(o_if[i]), 32'(m_byte[i][0][4]));
          check_output("rd", i, 32'(o_rd[i]), 32'(m_byte[i][0][3:2]));
          check_output("rs", i, 32'(o_rs[i]), 32'(m_byte[i][0][1:0]));
          check_output("imm", i, 32'(o_imm[i]), 32'((m_n[i] == 2) ? m_byte[i][1] : 8'h00));
        end
      end
    end
  end

  // Program memory: acks after delay[i] extra cycles of a steady request.
  logic       pend      [2];
  logic [7:0] pend_addr [2];
  int         wait_cnt  [2];
  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 1'b0; pend_addr[i] = '0; wait_cnt[i] = 0;
      ack_r[i] = 1'b0; rdata_r[i] = '0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 2; i++) begin
        if (o_req[i]) begin
          if (!pend[i] || o_addr[i] != pend_addr[i]) begin
            pend[i] = 1'b1; pend_addr[i] = o_addr[i]; wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
          end
          ack_r[i]   = (wait_cnt[i] >= delay[i]);
          rdata_r[i] = ack_r[i] ? mem[i][o_addr[i]] : 8'h00;
          if (ack_r[i]) pend[i] = 1'b0;
        end else begin
          pend[i] = 1'b0; ack_r[i] = 1'b0; rdata_r[i] = '0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int i, input logic st, input logic rdy,
                                input logic rv, input logic [7:0] ra);
    start_r[i] = st;
    ready_r[i] = rdy;
    redir_v[i] = rv;
    redir_a[i] = ra;
  endtask

  task automatic wait_until_valid(input int i, input int budget);
    int n = 0;
    while (!o_iv[i] && n < budget) begin tick(); n++; end
    check_output("issue_valid_timeout", i, 32'(o_iv[i]), 32'd1);
  endtask

  task automatic wait_fetch(input int i, input logic [7:0] addr, input int budget);
    int n = 0;
    while (!(o_req[i] && o_addr[i] == addr) && n < budget) begin tick(); n++; end
    check_output("fetch_addr_timeout", i, 32'(o_addr[i]), 32'(addr));
  endtask

  task automatic check_decode(input int i, input logic [2:0] op, input logic fl,
                              input logic [1:0] d, input logic [1:0] s, input logic [7:0] im);
    check_output("lit_opcode", i, 32'(o_op[i]), 32'(op));
    check_output("lit_imm_flag", i, 32'(o_if[i]), 32'(fl));
    check_output("lit_rd", i, 32'(o_rd[i]), 32'(d));
    check_output("lit_rs", i, 32'(o_rs[i]), 32'(s));
    check_output("lit_imm", i, 32'(o_imm[i]), 32'(im));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++) mem[i][a] = 8'h00;
      apply_stimulus(i, 1'b0, 1'b0, 1'b0, 8'h00);
      delay[i] = 0;
    end
    mem[0][8'h00] = 8'h0D; mem[0][8'h01] = 8'h3A; mem[0][8'h02] = 8'h7F;
    mem[0][8'h03] = 8'h5B; mem[0][8'h04] = 8'h99;
    mem[0][8'h20] = 8'h66; mem[0][8'h21] = 8'hB4; mem[0][8'h22] = 8'h11;
    mem[1][8'hFF] = 8'h40; mem[1][8'h00] = 8'hFF;

    rst_n = 1'b0;
    repeat (3) tick();
    check_output("reset_pc1", 1, 32'(o_pc[1]), 32'h0FF);
    check_output("reset_req", 0, 32'(o_req[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1-byte instruction, zero-wait memory.
    $display("[TB] one-byte fetch");
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_req_fetch0", 0, 32'(o_req[0]), 32'd1);
    check_output("lit_iv_fetch0", 0, 32'(o_iv[0]), 32'd0);
    tick();
    check_output("lit_iv_cycle2", 0, 32'(o_iv[0]), 32'd1);
    check_decode(0, 3'b000, 1'b0, 2'b11, 2'b01, 8'h00);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
    delay[0] = 3;
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_pc_after1", 0, 32'(o_pc[0]), 32'd1);
    check_output("lit_cnt_after1", 0, 32'(o_cnt[0]), 32'd1);

    // 2-byte instruction with 3-cycle waits, then 5 cycles of back-pressure.
    $display("[TB] two-byte fetch with wait states");
    wait_until_valid(0, 20);
    check_decode(0, 3'b001, 1'b1, 2'b10, 2'b10, 8'h7F);
    check_output("lit_pc_after2", 0, 32'(o_pc[0]), 32'd3);
    for (int c = 0; c < 5; c++) begin
      tick();
      check_output("lit_stall_iv", 0, 32'(o_iv[0]), 32'd1);
      check_output("lit_stall_req", 0, 32'(o_req[0]), 32'd0);
      check_output("lit_stall_cnt", 0, 32'(o_cnt[0]), 32'd1);
      check_decode(0, 3'b001, 1'b1, 2'b10, 2'b10, 8'h7F);
    end
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_cnt_after_stall", 0, 32'(o_cnt[0]), 32'd2);

    // Redirect during the second-byte wait, coinciding with a zero-wait ack.
    $display("[TB] redirect in FETCH1");
    wait_fetch(0, 8'h04, 20);
    apply_stimulus(0, 1'b0, 1'b0, 1'b1, 8'h20);
    delay[0] = 0;
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_redir_addr", 0, 32'(o_addr[0]), 32'h20);
    check_output("lit_redir_iv", 0, 32'(o_iv[0]), 32'd0);
    tick();
    check_output("lit_iv_at20", 0, 32'(o_iv[0]), 32'd1);
    check_decode(0, 3'b011, 1'b0, 2'b01, 2'b10, 8'h00);

    // Redirect coincident with an issue handshake still counts the instruction.
    $display("[TB] redirect with handshake");
    apply_stimulus(0, 1'b0, 1'b1, 1'b1, 8'h20);
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_cnt_redir", 0, 32'(o_cnt[0]), 32'd3);
    check_output("lit_pc_redir", 0, 32'(o_pc[0]), 32'h20);
    wait_until_valid(0, 5);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
    delay[0] = 3;
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_output("lit_cnt_4", 0, 32'(o_cnt[0]), 32'd4);

    // Asynchronous reset in the middle of a FETCH1 wait.
    $display("[TB] reset mid-fetch");
    wait_fetch(0, 8'h22, 20);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("lit_rst_req", 0, 32'(o_req[0]), 32'd0);
    check_output("lit_rst_pc", 0, 32'(o_pc[0]), 32'd0);
    check_output("lit_rst_cnt", 0, 32'(o_cnt[0]), 32'd0);
    check_decode(0, 3'b000, 1'b0, 2'b00, 2'b00, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("lit_idle_iv", 0, 32'(o_iv[0]), 32'd0);
      check_output("lit_idle_req", 0, 32'(o_req[0]), 32'd0);
    end
    delay[0] = 0;
    apply_stimulus(0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("lit_restart_iv", 0, 32'(o_iv[0]), 32'd1);
    check_decode(0, 3'b000, 1'b0, 2'b11, 2'b01, 8'h00);
    apply_stimulus(0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    apply_stimulus(0, 1'b0, 1'b0, 1'b0, 8'h00);

    // PC wrap from FF to 0, then HALT.
    $display("[TB] pc wrap and halt");
    apply_stimulus(1, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("lit_wrap_iv", 1, 32'(o_iv[1]), 32'd1);
    check_output("lit_wrap_pc", 1, 32'(o_pc[1]), 32'd0);
    check_decode(1, 3'b010, 1'b0, 2'b00, 2'b00, 8'h00);
    apply_stimulus(1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("lit_halted", 1, 32'(o_halt[1]), 32'd1);
    check_output("lit_halt_pc", 1, 32'(o_pc[1]), 32'd1);
    check_output("lit_halt_cnt", 1, 32'(o_cnt[1]), 32'd1);
    apply_stimulus(1, 1'b1, 1'b1, 1'b1, 8'h40);
    tick();
    apply_stimulus(1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int c = 0; c < 4; c++) begin
      tick();
      check_output("lit_halt_stay", 1, 32'(o_halt[1]), 32'd1);
      check_output("lit_halt_iv", 1, 32'(o_iv[1]), 32'd0);
      check_output("lit_halt_req", 1, 32'(o_req[1]), 32'd0);
      check_output("lit_halt_pc_hold", 1, 32'(o_pc[1]), 32'd1);
    end

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
